execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (IX, pipe stage 3) of the 16-bit uRISC pipeline.
- Holds the 8x16 architectural register file, written back from MEM/WB (p5).
- Reads the source operands and runs them through a combinational ALU/shifter.
- Registers result, destination, memory address and store data into the IX/MEM (p4) pipeline register.

Parameters:
- NUM_REGS, 8, architectural register count (index width 3)
- DATA_W, 16, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-low
- execute_valid_idix_p3  in  1  a valid instruction occupies IX
- ldst_valid_idix_p3  in  1  instruction is a load or store
- jmp_idix_p3  in  1  instruction is a jump/link
- uop_cnt_idix_p3  in  26  one-hot ALU micro-op
- rotate_shift_right_idix_p3  in  1  shift/rotate direction (1 = right)
- pc_p1  in  16  PC of next instruction (PC+2)
- inst_idix_p3  in  16  raw instruction word (immediate source)
- rs_idix_p3  in  3  source register A
- rt_idix_p3  in  3  source register B
- dest_reg_idix_p3  in  3  destination register
- reg_write_valid_idix_p3  in  1  instruction writes a register
- store_valid_idix_p3  in  2  [0] store; [1] store-with-update
- dest_reg_index_memwb_p5  in  3  writeback register index
- dest_reg_value_memwb_p5  in  16  writeback data
- dest_reg_write_valid_memwb_p5  in  1  writeback enable
- dest_reg_value_ixmem_p4  out  16  registered ALU result / link value
- dest_reg_index_ixmem_p4  out  3  registered destination index
- dest_reg_write_valid_ixmem_p4  out  1  registered write enable
- mem_addr_ixmem_p4  out  16  registered load/store address
- ldst_valid_ixmem_p4  out  1  registered load/store valid
- store_valid_ixmem_p4  out  2  registered store flags
- mem_data_in_ixmem_p4  out  16  registered store data

Behaviour:
- Register file, all 8 entries: 0 on reset; written at posedge when dest_reg_write_valid_memwb_p5.
- Reads are combinational with write-through: if the p5 write index equals rs/rt, the p5 value is read.
- Internal operand A is named rs_p1 and operand B is rt_p1. The bench forces rs_p1 hierarchically.
- Operand B is rt_p1, unless uop bit 13 is set. Then B = sign-extended inst_idix_p3[4:0], or zero-extended if bit 14 is also set.
- uop bits:
  - 0 ADD, 1 SUB (B-A), 2 XOR, 3 ANDN (A & ~B)
  - 4 ROT, 5 SHIFT
  - 6 SEQ, 7 SLT, 8 SLE, 9 SCO (carry-out of A+B); each gives 0/1
  - 10 BTR (bit-reverse A), 11 LBI (B), 12 SLBI ((A<<8)|B[7:0])
  - 15-25 reserved; produce 0
- All-zero uop (or reserved) yields ALU result 0.
- Shifter:
  - Amount shift_rotate_val = B[3:0].
  - With ROT clear: logical shift; right=1 gives A>>amt, right=0 gives A<<amt, zero-filled.
  - With ROT set: rotate in the selected direction.
  - Amount 0 passes A unchanged.
  - The shifter is evaluated whenever ROT is clear, independent of other bits; output is named shift_rotate_out.
- Result select: jmp_idix_p3 gives pc_p1 (link value); otherwise the ALU result.
- Memory address = A + sign-extended inst_idix_p3[4:0]. Store data = rt_p1 (forwarded).
- Store-with-update (store_valid[1]) also writes the address to dest_reg via the p4 result path.
- p4 register:
  - Latency is one cycle.
  - All p4 outputs are 0 on reset.
  - execute_valid=0 inserts a bubble: write_valid, ldst_valid and store_valid go to 0; other fields are don't-care (hold 0).
  - Reset mid-operation discards the in-flight instruction.

Optional Feature:
- EXECUTE_FWD_EN defined: operands also bypass from p4. If dest_reg_write_valid_ixmem_p4, ldst_valid_ixmem_p4=0, and the index matches rs/rt, use dest_reg_value_ixmem_p4.
- p4 has priority over the p5 write-through.
- Without EXECUTE_FWD_EN: regfile plus write-through only; hazards are left to upstream stalls.

Decomposition:
- Package uisc_ix_pkg:
  - uop bit-index localparams (UOP_ADD ... UOP_ZEXT)
  - DATA_W
  - register-index typedef
- Sub-module ix_alu (instance u_alu): combinational operand-B mux, arithmetic/logic, and shifter with internal shift_rotate_val/shift_rotate_out.

Test Plan:
- Logical right shift:
  - rs_p1 forced to 0x8FFF, uop=0, right=1, amt 0..15 via shift_rotate_val.
  - shift_rotate_out == 0x8FFF>>amt (amt 15 gives 0x0001), checked 2 time units after the negedge stimulus.
- Logical left shift:
  - Same as above with right=0.
  - shift_rotate_out == 0x8FFF<<amt truncated (amt 4 gives 0xFFF0, amt 15 gives 0x8000).
- ADD with writeback: r1=0x1234 and r2=0x0001 written via p5; ADD rs=1 rt=2 dest=3 -> next cycle dest_reg_value_ixmem_p4=0x1235, index 3, write_valid 1.
- Load address: r4=0x0100, imm=0x1F (-1), ldst_valid=1 -> mem_addr_ixmem_p4=0x00FF, ldst_valid_ixmem_p4=1.
- Write-through: p5 writes r5=0xBEEF in the same cycle that XOR reads rs=5, rt=0 (r0=0) -> result 0xBEEF.
- Reset and bubble:
  - rst=0 for one cycle -> all p4 outputs 0.
  - execute_valid=0 with reg_write_valid=1 -> dest_reg_write_valid_ixmem_p4=0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the uRISC execute stage: datapath sizes, one-hot
// micro-op bit positions and the register-index type.
package uisc_ix_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int UOP_W     = 26;

  localparam int UOP_ADD   = 0;
  localparam int UOP_SUB   = 1;
  localparam int UOP_XOR   = 2;
  localparam int UOP_ANDN  = 3;
  localparam int UOP_ROT   = 4;
  localparam int UOP_SHIFT = 5;
  localparam int UOP_SEQ   = 6;
  localparam int UOP_SLT   = 7;
  localparam int UOP_SLE   = 8;
  localparam int UOP_SCO   = 9;
  localparam int UOP_BTR   = 10;
  localparam int UOP_LBI   = 11;
  localparam int UOP_SLBI  = 12;
  localparam int UOP_IMM   = 13;
  localparam int UOP_ZEXT  = 14;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
    return {{(DATA_W-5){imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage: operand-B select, arithmetic,
// compares, bit manipulation and a shifter/rotator driven by B[3:0].
module ix_alu
  import uisc_ix_pkg::*;
(
  input  logic [UOP_W-1:0]  uop,
  input  logic              right,
  input  logic [4:0]        imm,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] rt_val,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0]   b;
  logic [3:0]          shift_rotate_val;
  logic [DATA_W-1:0]   shift_rotate_out;
  logic [2*DATA_W-1:0] dbl_r;
  logic [2*DATA_W-1:0] dbl_l;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   btr;
  logic                unused_uop;

  assign unused_uop = ^uop[UOP_W-1:UOP_ZEXT+1];

  assign b = uop[UOP_IMM] ? (uop[UOP_ZEXT] ? {{(DATA_W-5){1'b0}}, imm} : sext5(imm))
                          : rt_val;

  assign shift_rotate_val = b[3:0];
  assign sum              = {1'b0, a} + {1'b0, b};

  // Rotates come from a doubled copy of A so both directions share one shift.
  assign dbl_r = {a, a} >> shift_rotate_val;
  assign dbl_l = {a, a} << shift_rotate_val;

  always_comb begin
    shift_rotate_out = '0;
    if (uop[UOP_ROT])
      shift_rotate_out = right ? dbl_r[DATA_W-1:0] : dbl_l[2*DATA_W-1:DATA_W];
    else
      shift_rotate_out = right ? (a >> shift_rotate_val) : (a << shift_rotate_val);
  end

  always_comb begin
    btr = '0;
    for (int i = 0; i < DATA_W; i++)
      btr[i] = a[DATA_W-1-i];
  end

  always_comb begin
    result = '0;
    if (uop[UOP_ADD])
      result = sum[DATA_W-1:0];
    else if (uop[UOP_SUB])
      result = b - a;
    else if (uop[UOP_XOR])
      result = a ^ b;
    else if (uop[UOP_ANDN])
      result = a & ~b;
    else if (uop[UOP_ROT] || uop[UOP_SHIFT])
      result = shift_rotate_out;
    else if (uop[UOP_SEQ])
      result = {{(DATA_W-1){1'b0}}, (a == b)};
    else if (uop[UOP_SLT])
      result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
    else if (uop[UOP_SLE])
      result = {{(DATA_W-1){1'b0}}, ($signed(a) <= $signed(b))};
    else if (uop[UOP_SCO])
      result = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
    else if (uop[UOP_BTR])
      result = btr;
    else if (uop[UOP_LBI])
      result = b;
    else if (uop[UOP_SLBI])
      result = {a[7:0], b[7:0]};
  end

endmodule

// File: rtl/execute_stage.sv
// uRISC execute stage: register file with p5 write-through, ALU, and the IX/MEM
// pipeline register. Define EXECUTE_FWD_EN to add operand bypass from p4.
module execute_stage
  import uisc_ix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              execute_valid_idix_p3,
  input  logic              ldst_valid_idix_p3,
  input  logic              jmp_idix_p3,
  input  logic [25:0]       uop_cnt_idix_p3,
  input  logic              rotate_shift_right_idix_p3,
  input  logic [15:0]       pc_p1,
  input  logic [15:0]       inst_idix_p3,
  input  logic [2:0]        rs_idix_p3,
  input  logic [2:0]        rt_idix_p3,
  input  logic [2:0]        dest_reg_idix_p3,
  input  logic              reg_write_valid_idix_p3,
  input  logic [1:0]        store_valid_idix_p3,
  input  logic [2:0]        dest_reg_index_memwb_p5,
  input  logic [15:0]       dest_reg_value_memwb_p5,
  input  logic              dest_reg_write_valid_memwb_p5,
  output logic [15:0]       dest_reg_value_ixmem_p4,
  output logic [2:0]        dest_reg_index_ixmem_p4,
  output logic              dest_reg_write_valid_ixmem_p4,
  output logic [15:0]       mem_addr_ixmem_p4,
  output logic              ldst_valid_ixmem_p4,
  output logic [1:0]        store_valid_ixmem_p4,
  output logic [15:0]       mem_data_in_ixmem_p4
);

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] rs_p1;
  logic [DATA_W-1:0] rt_p1;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] result;
  logic              unused_inst;

  assign unused_inst = ^inst_idix_p3[DATA_W-1:5];

  // Operand read: regfile, overridden by the same-cycle p5 write (and p4 when bypassing).
  always_comb begin
    rs_p1 = rf[rs_idix_p3];
    rt_p1 = rf[rt_idix_p3];
    if (dest_reg_write_valid_memwb_p5 && dest_reg_index_memwb_p5 == rs_idix_p3)
      rs_p1 = dest_reg_value_memwb_p5;
    if (dest_reg_write_valid_memwb_p5 && dest_reg_index_memwb_p5 == rt_idix_p3)
      rt_p1 = dest_reg_value_memwb_p5;
`ifdef EXECUTE_FWD_EN
    if (dest_reg_write_valid_ixmem_p4 && !ldst_valid_ixmem_p4 &&
        dest_reg_index_ixmem_p4 == rs_idix_p3)
      rs_p1 = dest_reg_value_ixmem_p4;
    if (dest_reg_write_valid_ixmem_p4 && !ldst_valid_ixmem_p4 &&
        dest_reg_index_ixmem_p4 == rt_idix_p3)
      rt_p1 = dest_reg_value_ixmem_p4;
`endif
  end

  ix_alu u_alu (
    .uop    (uop_cnt_idix_p3),
    .right  (rotate_shift_right_idix_p3),
    .imm    (inst_idix_p3[4:0]),
    .a      (rs_p1),
    .rt_val (rt_p1),
    .result (alu_result)
  );

  assign mem_addr = rs_p1 + sext5(inst_idix_p3[4:0]);

  // Link value wins, then the store-with-update address, then the ALU.
  always_comb begin
    result = alu_result;
    if (jmp_idix_p3)
      result = pc_p1;
    else if (store_valid_idix_p3[1])
      result = mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (dest_reg_write_valid_memwb_p5) begin
      rf[dest_reg_index_memwb_p5] <= dest_reg_value_memwb_p5;
    end
  end

  // A bubble (execute_valid low) loads an all-zero p4 entry.
  always_ff @(posedge clk) begin
    if (!rst || !execute_valid_idix_p3) begin
      dest_reg_value_ixmem_p4       <= '0;
      dest_reg_index_ixmem_p4       <= '0;
      dest_reg_write_valid_ixmem_p4 <= 1'b0;
      mem_addr_ixmem_p4             <= '0;
      ldst_valid_ixmem_p4           <= 1'b0;
      store_valid_ixmem_p4          <= '0;
      mem_data_in_ixmem_p4          <= '0;
    end else begin
      dest_reg_value_ixmem_p4       <= result;
      dest_reg_index_ixmem_p4       <= dest_reg_idix_p3;
      dest_reg_write_valid_ixmem_p4 <= reg_write_valid_idix_p3 | store_valid_idix_p3[1];
      mem_addr_ixmem_p4             <= mem_addr;
      ldst_valid_ixmem_p4           <= ldst_valid_idix_p3;
      store_valid_ixmem_p4          <= store_valid_idix_p3;
      mem_data_in_ixmem_p4          <= rt_p1;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed shifter/ALU/address/reset checks, then random
// instructions against a behavioural model of the register file and ALU.
module tb_execute_stage;

  localparam int EXP_W = 55;

  logic        clk = 1'b0;
  logic        rst;
  logic        execute_valid_idix_p3;
  logic        ldst_valid_idix_p3;
  logic        jmp_idix_p3;
  logic [25:0] uop_cnt_idix_p3;
  logic        rotate_shift_right_idix_p3;
  logic [15:0] pc_p1;
  logic [15:0] inst_idix_p3;
  logic [2:0]  rs_idix_p3;
  logic [2:0]  rt_idix_p3;
  logic [2:0]  dest_reg_idix_p3;
  logic        reg_write_valid_idix_p3;
  logic [1:0]  store_valid_idix_p3;
  logic [2:0]  dest_reg_index_memwb_p5;
  logic [15:0] dest_reg_value_memwb_p5;
  logic        dest_reg_write_valid_memwb_p5;
  logic [15:0] dest_reg_value_ixmem_p4;
  logic [2:0]  dest_reg_index_ixmem_p4;
  logic        dest_reg_write_valid_ixmem_p4;
  logic [15:0] mem_addr_ixmem_p4;
  logic        ldst_valid_ixmem_p4;
  logic [1:0]  store_valid_ixmem_p4;
  logic [15:0] mem_data_in_ixmem_p4;

  int total = 0;
  int bad   = 0;

  logic [15:0]      model_rf [8];
  logic [EXP_W-1:0] prev_exp;
  logic [EXP_W-1:0] exp_q [$];
  logic [3:0]       amt4;

  execute_stage dut (
    .clk                           (clk),
    .rst                           (rst),
    .execute_valid_idix_p3         (execute_valid_idix_p3),
    .ldst_valid_idix_p3            (ldst_valid_idix_p3),
    .jmp_idix_p3                   (jmp_idix_p3),
    .uop_cnt_idix_p3               (uop_cnt_idix_p3),
    .rotate_shift_right_idix_p3    (rotate_shift_right_idix_p3),
    .pc_p1                         (pc_p1),
    .inst_idix_p3                  (inst_idix_p3),
    .rs_idix_p3                    (rs_idix_p3),
    .rt_idix_p3                    (rt_idix_p3),
    .dest_reg_idix_p3              (dest_reg_idix_p3),
    .reg_write_valid_idix_p3       (reg_write_valid_idix_p3),
    .store_valid_idix_p3           (store_valid_idix_p3),
    .dest_reg_index_memwb_p5       (dest_reg_index_memwb_p5),
    .dest_reg_value_memwb_p5       (dest_reg_value_memwb_p5),
    .dest_reg_write_valid_memwb_p5 (dest_reg_write_valid_memwb_p5),
    .dest_reg_value_ixmem_p4       (dest_reg_value_ixmem_p4),
    .dest_reg_index_ixmem_p4       (dest_reg_index_ixmem_p4),
    .dest_reg_write_valid_ixmem_p4 (dest_reg_write_valid_ixmem_p4),
    .mem_addr_ixmem_p4             (mem_addr_ixmem_p4),
    .ldst_valid_ixmem_p4           (ldst_valid_ixmem_p4),
    .store_valid_ixmem_p4          (store_valid_ixmem_p4),
    .mem_data_in_ixmem_p4          (mem_data_in_ixmem_p4)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [15:0] model_alu(input logic [25:0] uop, input logic right,
                                            input logic [15:0] a, input logic [15:0] rt_v,
                                            input logic [4:0] imm);
    logic [15:0] bb;
    int ai, bi, n, op;
    logic [15:0] rev;
    if (uop[13]) bb = uop[14] ? {11'd0, imm} : {{11{imm[4]}}, imm};
    else         bb = rt_v;
    ai = int'(a);
    bi = int'(bb);
    n  = bi % 16;
    op = -1;
    for (int i = 0; i <= 12; i++) if (uop[i]) op = i;
    for (int i = 15; i <= 25; i++) if (uop[i]) op = -1;
    case (op)
      0:  return 16'(ai + bi);
      1:  return 16'(bi - ai);
      2:  return 16'(ai ^ bi);
      3:  return 16'(ai & ~bi);
      4:  return right ? 16'((ai >> n) | (ai << (16 - n))) : 16'((ai << n) | (ai >> (16 - n)));
      5:  return right ? 16'(ai >> n) : 16'(ai << n);
      6:  return (ai == bi) ? 16'd1 : 16'd0;
      7:  return (shortint'(a) <  shortint'(bb)) ? 16'd1 : 16'd0;
      8:  return (shortint'(a) <= shortint'(bb)) ? 16'd1 : 16'd0;
      9:  return (ai + bi > 65535) ? 16'd1 : 16'd0;
      10: begin
        for (int i = 0; i < 16; i++) rev[i] = a[15 - i];
        return rev;
      end
      11: return bb;
      12: return 16'(ai * 256 + (bi % 256));
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] idx);
    logic [15:0] v;
    v = model_rf[idx];
    if (dest_reg_write_valid_memwb_p5 && dest_reg_index_memwb_p5 == idx) v = dest_reg_value_memwb_p5;
`ifdef EXECUTE_FWD_EN
    if (prev_exp[35] && !prev_exp[18] && prev_exp[38:36] == idx) v = prev_exp[54:39];
`endif
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] model_p4();
    logic [15:0] a, b, addr, val;
    if (!rst || !execute_valid_idix_p3) return '0;
    a    = model_read(rs_idix_p3);
    b    = model_read(rt_idix_p3);
    addr = 16'(int'(a) + int'({{11{inst_idix_p3[4]}}, inst_idix_p3[4:0]}));
    if (jmp_idix_p3)                 val = pc_p1;
    else if (store_valid_idix_p3[1]) val = addr;
    else val = model_alu(uop_cnt_idix_p3, rotate_shift_right_idix_p3, a, b, inst_idix_p3[4:0]);
    return {val, dest_reg_idix_p3, reg_write_valid_idix_p3 | store_valid_idix_p3[1],
            addr, ldst_valid_idix_p3, store_valid_idix_p3, b};
  endfunction

  // driver tasks
  task automatic drive_idle();
    execute_valid_idix_p3         = 1'b0;
    ldst_valid_idix_p3            = 1'b0;
    jmp_idix_p3                   = 1'b0;
    uop_cnt_idix_p3               = '0;
    rotate_shift_right_idix_p3    = 1'b0;
    pc_p1                         = '0;
    inst_idix_p3                  = '0;
    rs_idix_p3                    = '0;
    rt_idix_p3                    = '0;
    dest_reg_idix_p3              = '0;
    reg_write_valid_idix_p3       = 1'b0;
    store_valid_idix_p3           = '0;
    dest_reg_index_memwb_p5       = '0;
    dest_reg_value_memwb_p5       = '0;
    dest_reg_write_valid_memwb_p5 = 1'b0;
  endtask

  task automatic p5_write(input logic [2:0] idx, input logic [15:0] val);
    dest_reg_index_memwb_p5       = idx;
    dest_reg_value_memwb_p5       = val;
    dest_reg_write_valid_memwb_p5 = 1'b1;
  endtask

  task automatic drive_random();
    int op;
    execute_valid_idix_p3      = ($urandom_range(0, 7) != 0);
    ldst_valid_idix_p3         = ($urandom_range(0, 3) == 0);
    jmp_idix_p3                = ($urandom_range(0, 7) == 0);
    op                         = $urandom_range(0, 26);
    uop_cnt_idix_p3            = (op == 26) ? 26'd0 : (26'd1 << op);
    if ($urandom_range(0, 3) == 0) uop_cnt_idix_p3[13] = 1'b1;
    if ($urandom_range(0, 3) == 0) uop_cnt_idix_p3[14] = 1'b1;
    rotate_shift_right_idix_p3 = 1'($urandom_range(0, 1));
    pc_p1                      = 16'($urandom);
    inst_idix_p3               = 16'($urandom);
    rs_idix_p3                 = 3'($urandom_range(0, 7));
    rt_idix_p3                 = 3'($urandom_range(0, 7));
    dest_reg_idix_p3           = 3'($urandom_range(0, 7));
    reg_write_valid_idix_p3    = 1'($urandom_range(0, 1));
    store_valid_idix_p3        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
    dest_reg_write_valid_memwb_p5 = 1'($urandom_range(0, 1));
    dest_reg_index_memwb_p5    = 3'($urandom_range(0, 7));
    dest_reg_value_memwb_p5    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
  endtask

  // scoreboard: one clock, expected entry checked one cycle later
  task automatic tick();
    logic [EXP_W-1:0] e;
    exp_q.push_back(model_p4());
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) model_rf[i] = '0;
    end else if (dest_reg_write_valid_memwb_p5) begin
      model_rf[dest_reg_index_memwb_p5] = dest_reg_value_memwb_p5;
    end
    #1;
    e = exp_q.pop_front();
    prev_exp = e;
    chk("p4_value", 32'(dest_reg_value_ixmem_p4), 32'(e[54:39]));
    chk("p4_index", 32'(dest_reg_index_ixmem_p4), 32'(e[38:36]));
    chk("p4_wv",    32'(dest_reg_write_valid_ixmem_p4), 32'(e[35]));
    chk("p4_addr",  32'(mem_addr_ixmem_p4), 32'(e[34:19]));
    chk("p4_ldst",  32'(ldst_valid_ixmem_p4), 32'(e[18]));
    chk("p4_store", 32'(store_valid_ixmem_p4), 32'(e[17:16]));
    chk("p4_data",  32'(mem_data_in_ixmem_p4), 32'(e[15:0]));
  endtask

  initial begin
    prev_exp = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    drive_idle();
    rst = 1'b0;
    tick();
    tick();
    chk("reset_value", 32'(dest_reg_value_ixmem_p4), 32'h0);
    chk("reset_wv",    32'(dest_reg_write_valid_ixmem_p4), 32'h0);
    rst = 1'b1;

    // shifter in isolation, operands forced
    for (int dir = 1; dir >= 0; dir--) begin
      for (int amt = 0; amt < 16; amt++) begin
        @(negedge clk);
        amt4 = 4'(amt);
        rotate_shift_right_idix_p3 = 1'(dir);
        uop_cnt_idix_p3 = '0;
        force dut.rs_p1 = 16'h8FFF;
        force dut.u_alu.shift_rotate_val = amt4;
        #2;
        if (dir == 1) chk("shr", 32'(dut.u_alu.shift_rotate_out), 32'(16'h8FFF >> amt));
        else          chk("shl", 32'(dut.u_alu.shift_rotate_out), 32'(16'(32'h8FFF << amt)));
      end
    end
    @(negedge clk);
    release dut.rs_p1;
    release dut.u_alu.shift_rotate_val;
    drive_idle();
    prev_exp = '0;

    // ADD with writeback operands
    p5_write(3'd1, 16'h1234); tick();
    p5_write(3'd2, 16'h0001); tick();
    drive_idle();
    execute_valid_idix_p3 = 1'b1; uop_cnt_idix_p3 = 26'd1;
    rs_idix_p3 = 3'd1; rt_idix_p3 = 3'd2; dest_reg_idix_p3 = 3'd3; reg_write_valid_idix_p3 = 1'b1;
    tick();
    chk("add_value", 32'(dest_reg_value_ixmem_p4), 32'h1235);
    chk("add_index", 32'(dest_reg_index_ixmem_p4), 32'd3);
    chk("add_wv",    32'(dest_reg_write_valid_ixmem_p4), 32'd1);

    // load address with negative immediate
    drive_idle();
    p5_write(3'd4, 16'h0100); tick();
    drive_idle();
    execute_valid_idix_p3 = 1'b1; ldst_valid_idix_p3 = 1'b1; rs_idix_p3 = 3'd4;
    inst_idix_p3 = 16'h001F; reg_write_valid_idix_p3 = 1'b1; dest_reg_idix_p3 = 3'd6;
    tick();
    chk("ld_addr", 32'(mem_addr_ixmem_p4), 32'h00FF);
    chk("ld_valid", 32'(ldst_valid_ixmem_p4), 32'd1);

    // same-cycle write-through
    drive_idle();
    p5_write(3'd5, 16'hBEEF);
    execute_valid_idix_p3 = 1'b1; uop_cnt_idix_p3 = 26'd1 << 2;
    rs_idix_p3 = 3'd5; rt_idix_p3 = 3'd0; dest_reg_idix_p3 = 3'd7; reg_write_valid_idix_p3 = 1'b1;
    tick();
    chk("wt_value", 32'(dest_reg_value_ixmem_p4), 32'hBEEF);

    // reset mid-operation, then a bubble
    drive_idle();
    execute_valid_idix_p3 = 1'b1; uop_cnt_idix_p3 = 26'd1; reg_write_valid_idix_p3 = 1'b1;
    rs_idix_p3 = 3'd5; ldst_valid_idix_p3 = 1'b1; store_valid_idix_p3 = 2'd1;
    rst = 1'b0;
    tick();
    chk("rst_value", 32'(dest_reg_value_ixmem_p4), 32'h0);
    chk("rst_ldst",  32'(ldst_valid_ixmem_p4), 32'h0);
    chk("rst_store", 32'(store_valid_ixmem_p4), 32'h0);
    rst = 1'b1;
    execute_valid_idix_p3 = 1'b0;
    tick();
    chk("bubble_wv", 32'(dest_reg_write_valid_ixmem_p4), 32'h0);

    // random instruction stream
    for (int n = 0; n < 400; n++) begin
      drive_random();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
